// File: rtl/cpu_pkg.sv
// Shared decode constants, bus widths and forward-bus helpers for the ID stage.
package cpu_pkg;

    // Bus widths.
    localparam int FS_TO_DS_W = 65;
    localparam int DS_TO_ES_W = 132;
    localparam int BR_BUS_W   = 35;
    // Forward bus layout {valid, we, wait, dest[4:0], value[31:0]} takes 40 bits.
    localparam int FWD_W      = 40;

    // Forward-bus field offsets.
    localparam int FWD_VALUE_LSB = 0;
    localparam int FWD_DEST_LSB  = 32;
    localparam int FWD_WAIT_BIT  = 37;
    localparam int FWD_WE_BIT    = 38;
    localparam int FWD_VALID_BIT = 39;

    // Branch/jump opcodes in inst[31:26].
    localparam logic [5:0] OP_JIRL = 6'h13;
    localparam logic [5:0] OP_B    = 6'h14;
    localparam logic [5:0] OP_BL   = 6'h15;
    localparam logic [5:0] OP_BEQ  = 6'h16;
    localparam logic [5:0] OP_BNE  = 6'h17;
    localparam logic [5:0] OP_BLT  = 6'h18;
    localparam logic [5:0] OP_BGE  = 6'h19;
    localparam logic [5:0] OP_BLTU = 6'h1a;
    localparam logic [5:0] OP_BGEU = 6'h1b;

    // Trap codes in inst[31:15].
    localparam logic [16:0] CODE_SYSCALL = 17'h00056;
    localparam logic [16:0] CODE_BREAK   = 17'h00054;

    // Store opcodes in inst[31:22] (st.b, st.h, st.w).
    localparam logic [9:0] OP_ST_B = 10'h0a4;
    localparam logic [9:0] OP_ST_H = 10'h0a5;
    localparam logic [9:0] OP_ST_W = 10'h0a6;

    function automatic logic is_cond_br(input logic [5:0] op);
        return (op >= OP_BEQ) && (op <= OP_BGEU);
    endfunction

    function automatic logic is_store(input logic [9:0] op10);
        return (op10 >= OP_ST_B) && (op10 <= OP_ST_W);
    endfunction

    function automatic logic fwd_hit(input logic [FWD_W-1:0] f, input logic [4:0] addr);
        return f[FWD_VALID_BIT] & f[FWD_WE_BIT] & (f[FWD_DEST_LSB +: 5] == addr);
    endfunction

    // Returns {wait, value} of the highest-priority source for one operand.
    // r0 reads as zero and never produces a wait.
    function automatic logic [32:0] resolve_src(
        input logic [4:0]       addr,
        input logic [FWD_W-1:0] es,
        input logic [FWD_W-1:0] ms,
        input logic [FWD_W-1:0] ws,
        input logic [31:0]      rf
    );
        logic [32:0] r;
        if (addr == 5'd0) begin
            r = 33'd0;
        end else if (fwd_hit(es, addr)) begin
            r = {es[FWD_WAIT_BIT], es[FWD_VALUE_LSB +: 32]};
        end else if (fwd_hit(ms, addr)) begin
            r = {ms[FWD_WAIT_BIT], ms[FWD_VALUE_LSB +: 32]};
        end else if (fwd_hit(ws, addr)) begin
            r = {ws[FWD_WAIT_BIT], ws[FWD_VALUE_LSB +: 32]};
        end else begin
            r = {1'b0, rf};
        end
        return r;
    endfunction

endpackage

// File: rtl/decode_branch_stage_br_unit.sv
// Combinational branch condition and target generation for ID-stage branches.
module br_unit
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic [31:0] rj_value,
    input  logic [31:0] rkd_value,
    output logic        is_br,
    output logic        taken,
    output logic [31:0] target
);

    logic [5:0]  opcode_s;
    logic [31:0] offs16_s;
    logic [31:0] offs26_s;

    assign opcode_s = inst[31:26];
    assign offs16_s = {{14{inst[25]}}, inst[25:10], 2'b00};
    assign offs26_s = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};

    // Decode branch kind, evaluate its condition and form the wrapped target.
    always_comb begin
        is_br  = 1'b0;
        taken  = 1'b0;
        target = 32'h0000_0000;
        case (opcode_s)
            OP_JIRL: begin
                is_br  = 1'b1;
                taken  = 1'b1;
                target = rj_value + offs16_s;
            end
            OP_B, OP_BL: begin
                is_br  = 1'b1;
                taken  = 1'b1;
                target = pc + offs26_s;
            end
            OP_BEQ: begin
                is_br  = 1'b1;
                taken  = (rj_value == rkd_value);
                target = pc + offs16_s;
            end
            OP_BNE: begin
                is_br  = 1'b1;
                taken  = (rj_value != rkd_value);
                target = pc + offs16_s;
            end
            OP_BLT: begin
                is_br  = 1'b1;
                taken  = ($signed(rj_value) < $signed(rkd_value));
                target = pc + offs16_s;
            end
            OP_BGE: begin
                is_br  = 1'b1;
                taken  = ($signed(rj_value) >= $signed(rkd_value));
                target = pc + offs16_s;
            end
            OP_BLTU: begin
                is_br  = 1'b1;
                taken  = (rj_value < rkd_value);
                target = pc + offs16_s;
            end
            OP_BGEU: begin
                is_br  = 1'b1;
                taken  = (rj_value >= rkd_value);
                target = pc + offs16_s;
            end
            default: begin
                is_br  = 1'b0;
                taken  = 1'b0;
                target = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/decode_branch_stage.sv
// ID stage front end: register read, operand forwarding/stall, branch resolution.
module decode_branch_stage
    import cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fs_to_ds_valid,
    input  logic [FS_TO_DS_W-1:0]  fs_to_ds_bus,
    output logic                   ds_allowin,
    input  logic                   es_allowin,
    output logic                   ds_to_es_valid,
    output logic [DS_TO_ES_W-1:0]  ds_to_es_bus,
    output logic [BR_BUS_W-1:0]    br_bus,
    output logic [4:0]             rf_raddr1,
    output logic [4:0]             rf_raddr2,
    input  logic [31:0]            rf_rdata1,
    input  logic [31:0]            rf_rdata2,
    input  logic [FWD_W-1:0]       es_fwd,
    input  logic [FWD_W-1:0]       ms_fwd,
    input  logic [FWD_W-1:0]       ws_fwd,
    input  logic                   wb_flush
);

    logic                  ds_valid_r;
    logic [FS_TO_DS_W-1:0] fs_bus_r;

    logic        adef_s;
    logic [31:0] inst_s;
    logic [31:0] pc_s;
    logic [5:0]  opcode_s;
    logic [4:0]  rj_s;
    logic [4:0]  rk_s;
    logic [4:0]  rd_s;
    logic        use_rd_s;
    logic [32:0] src1_s;
    logic [32:0] src2_s;
    logic        ds_ready_go_s;
    logic        ds_allowin_s;
    logic        is_br_s;
    logic        br_cond_s;
    logic [31:0] br_target_raw_s;
    logic        br_taken_s;
    logic        br_stall_s;
    logic        br_cancel_s;
    logic [31:0] br_target_s;
    logic        kill_next_s;
    logic        link_s;
    logic        ex_sys_s;
    logic        ex_brk_s;

    assign adef_s   = fs_bus_r[64];
    assign inst_s   = fs_bus_r[63:32];
    assign pc_s     = fs_bus_r[31:0];
    assign opcode_s = inst_s[31:26];
    assign rj_s     = inst_s[9:5];
    assign rk_s     = inst_s[14:10];
    assign rd_s     = inst_s[4:0];

    // Second read port uses rd for compare-branches and stores, rk otherwise.
    always_comb begin
        use_rd_s = 1'b0;
        if (is_cond_br(opcode_s) || is_store(inst_s[31:22])) begin
            use_rd_s = 1'b1;
        end else begin
            use_rd_s = 1'b0;
        end
    end

    assign rf_raddr1 = rj_s;
    assign rf_raddr2 = use_rd_s ? rd_s : rk_s;

    // Resolve both operands through EX/MEM/WB forwarding and flag load-use waits.
    always_comb begin
        src1_s = resolve_src(rf_raddr1, es_fwd, ms_fwd, ws_fwd, rf_rdata1);
        src2_s = resolve_src(rf_raddr2, es_fwd, ms_fwd, ws_fwd, rf_rdata2);
    end

    br_unit u_br_unit (
        .pc        (pc_s),
        .inst      (inst_s),
        .rj_value  (src1_s[31:0]),
        .rkd_value (src2_s[31:0]),
        .is_br     (is_br_s),
        .taken     (br_cond_s),
        .target    (br_target_raw_s)
    );

    // Handshake and branch-redirect signalling back to fetch.
    always_comb begin
        // A fetch-faulted instruction carries no usable operands, so it never waits.
        ds_ready_go_s = adef_s | ~(src1_s[32] | src2_s[32]);
        ds_allowin_s  = ~ds_valid_r | (ds_ready_go_s & es_allowin);
        br_taken_s    = ds_valid_r & is_br_s & br_cond_s & ~adef_s & ~wb_flush;
        br_stall_s    = ds_valid_r & is_br_s & ~ds_ready_go_s;
        br_cancel_s   = br_taken_s & ds_ready_go_s & es_allowin;
        // The sequential instruction fetched alongside a leaving taken branch is wrong-path.
        kill_next_s   = br_taken_s & ds_ready_go_s & es_allowin;
        br_target_s   = br_taken_s ? br_target_raw_s : 32'h0000_0000;
    end

    // Link and trap flags carried to EX for the remaining decode.
    always_comb begin
        link_s   = (opcode_s == OP_BL) | (opcode_s == OP_JIRL);
        ex_sys_s = (inst_s[31:15] == CODE_SYSCALL);
        ex_brk_s = (inst_s[31:15] == CODE_BREAK);
    end

    assign ds_allowin     = ds_allowin_s;
    assign ds_to_es_valid = ds_valid_r & ds_ready_go_s & ~wb_flush;
    assign br_bus         = {br_stall_s, br_cancel_s, br_taken_s, br_target_s};
    assign ds_to_es_bus   = {adef_s, ex_sys_s, ex_brk_s, link_s,
                             src2_s[31:0], src1_s[31:0], inst_s, pc_s};

    // ID pipeline register: flush empties the stage, otherwise capture on allowin.
    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid_r <= 1'b0;
            fs_bus_r   <= {FS_TO_DS_W{1'b0}};
        end else begin
            if (wb_flush) begin
                ds_valid_r <= 1'b0;
            end else if (ds_allowin_s) begin
                ds_valid_r <= fs_to_ds_valid & ~kill_next_s;
            end
            if (ds_allowin_s) begin
                fs_bus_r <= fs_to_ds_bus;
            end
        end
    end

endmodule
